fp_op_sched: RTL and testbench

Multi-cycle scheduler that shares the floating-point path of the ALU (combinational FP adder/multiplier, selected by Op=2'b11) between two requesters: the scalar datapath (port 0) and the vector unit (port 1). It arbitrates, registers operands so they stay stable across a configurable multicycle settle window, then captures result and flags. It returns them to the winning requester through a valid/ready response.

---
 rtl/fp_sched_pkg.sv | 22 ++
 rtl/fp_sched_arb2.sv | 26 ++
 rtl/fp_op_sched.sv | 146 ++++++++++++++
 tb/tb_fp_op_sched.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sched_pkg.sv
// Shared constants, state encoding and settle-count helper for the FP operation scheduler.
package fp_sched_pkg;

  localparam int         CNT_W           = 4;
  localparam logic [3:0] FUNCT_FADD_CODE = 4'b0000;
  localparam logic [1:0] OP_FP           = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Any code other than the add code settles for the multiply window.
  function automatic logic [CNT_W-1:0] settle_load(input logic [3:0] code,
                                                   input int add_c,
                                                   input int mul_c);
    if (code == FUNCT_FADD_CODE) return CNT_W'(add_c - 1);
    else                         return CNT_W'(mul_c - 1);
  endfunction

endpackage

// File: rtl/fp_sched_arb2.sv
// Two-way grant logic. FP_SCHED_RR_ARB_EN selects round-robin, otherwise fixed priority to requester 0.
module fp_sched_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last,
  output logic [1:0] grant
);

`ifdef FP_SCHED_RR_ARB_EN
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant = 2'b00;
    if (req_valid == 2'b11) grant = last ? 2'b01 : 2'b10;
    else                    grant = req_valid;
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    grant = 2'b00;
    if      (req_valid[0]) grant = 2'b01;
    else if (req_valid[1]) grant = 2'b10;
  end
`endif

endmodule

// File: rtl/fp_op_sched.sv
// Shares the combinational FP add/multiply path between two requesters over a multicycle settle window.
// Optional macro FP_SCHED_RR_ARB_EN enables round-robin arbitration (default: fixed priority).
module fp_op_sched
  import fp_sched_pkg::*;
#(
  parameter int ADD_CYCLES = 2,
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [5:0]  req0_funct,
  input  logic [5:0]  req1_funct,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [5:0]  fpu_funct,
  input  logic [31:0] fpu_result,
  input  logic [3:0]  fpu_flags,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  input  logic [1:0]  rsp_ready,
  output logic        busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic [31:0]      fpu_a_q, fpu_a_d;
  logic [31:0]      fpu_b_q, fpu_b_d;
  logic [5:0]       fpu_funct_q, fpu_funct_d;
  logic [31:0]      rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic             last;
  logic [1:0]       grant;
  logic             accept;
  logic [31:0]      sel_a, sel_b;
  logic [5:0]       sel_funct;

`ifdef FP_SCHED_RR_ARB_EN
  logic last_q, last_d;
  assign last = last_q;
`else
  assign last = 1'b1;
`endif

  fp_sched_arb2 u_arb (
    .req_valid (req_valid),
    .last      (last),
    .grant     (grant)
  );

  assign req_ready = (state_q == ST_IDLE) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign sel_a     = grant[1] ? req1_a     : req0_a;
  assign sel_b     = grant[1] ? req1_b     : req0_b;
  assign sel_funct = grant[1] ? req1_funct : req0_funct;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    fpu_a_d      = fpu_a_q;
    fpu_b_d      = fpu_b_q;
    fpu_funct_d  = fpu_funct_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
`ifdef FP_SCHED_RR_ARB_EN
    last_d       = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          fpu_a_d     = sel_a;
          fpu_b_d     = sel_b;
          fpu_funct_d = sel_funct;
          owner_d     = grant[1];
          cnt_d       = settle_load(sel_funct[4:1], ADD_CYCLES, MUL_CYCLES);
          state_d     = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          rsp_result_d = fpu_result;
          rsp_flags_d  = fpu_flags;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        // The non-owner's rsp_ready never completes the response.
        if (rsp_ready[owner_q]) begin
          state_d = ST_IDLE;
`ifdef FP_SCHED_RR_ARB_EN
          last_d  = owner_q;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      fpu_a_q      <= '0;
      fpu_b_q      <= '0;
      fpu_funct_q  <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
`ifdef FP_SCHED_RR_ARB_EN
      last_q       <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      fpu_a_q      <= fpu_a_d;
      fpu_b_q      <= fpu_b_d;
      fpu_funct_q  <= fpu_funct_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
`ifdef FP_SCHED_RR_ARB_EN
      last_q       <= last_d;
`endif
    end
  end

  assign fpu_a      = fpu_a_q;
  assign fpu_b      = fpu_b_q;
  assign fpu_funct  = fpu_funct_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_valid  = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fp_op_sched.sv
// Scoreboard bench for fp_op_sched: directed requests push expectations, a monitor pops them on each response.
module tb_fp_op_sched;

  localparam int ADD_N = 2;
  localparam int MUL_N = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [5:0]  req0_funct = '0, req1_funct = '0;
  logic [31:0] fpu_a, fpu_b;
  logic [5:0]  fpu_funct;
  logic [31:0] fpu_result;
  logic [3:0]  fpu_flags;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [1:0]  rsp_ready = 2'b11;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0]  owner_oh;
    logic [31:0] result;
    logic [3:0]  flags;
    int          acc;
    int          n;
  } exp_t;
  exp_t sb[$];

  fp_op_sched #(.ADD_CYCLES(ADD_N), .MUL_CYCLES(MUL_N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_funct(req0_funct), .req1_funct(req1_funct),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_funct(fpu_funct),
    .fpu_result(fpu_result), .fpu_flags(fpu_flags),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU stand-in: table of hand-computed IEEE-754 results for the directed operands.
  always_comb begin
    case ({fpu_a, fpu_b, fpu_funct})
      {32'h3FC00000, 32'h40100000, 6'b000000}: fpu_result = 32'h40700000;
      {32'h40000000, 32'h40400000, 6'b000010}: fpu_result = 32'h40C00000;
      {32'h3F800000, 32'hBF800000, 6'b000000}: fpu_result = 32'h00000000;
      default:                                 fpu_result = 32'h7FC00000;
    endcase
    fpu_flags = {fpu_result[31], fpu_result == 32'h0, 1'b0, fpu_funct[1]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int p, input logic [31:0] res, input logic [3:0] fl,
                          input int n, input int acc);
    exp_t e;
    e.owner_oh = (p == 1) ? 2'b10 : 2'b01;
    e.result   = res;
    e.flags    = fl;
    e.acc      = acc;
    e.n        = n;
    sb.push_back(e);
  endtask

  // Caller drives req_valid at a negedge; returns once req_ready[p] is seen or the budget expires.
  task automatic wait_ready(input int p, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (req_ready[p]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("req_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input int p, input logic [31:0] a, input logic [31:0] b,
                      input logic [5:0] f, input logic [31:0] res, input logic [3:0] fl,
                      input bit expect_rsp, output int acc);
    bit ok;
    int n;
    n = (f[4:1] == 4'b0000) ? ADD_N : MUL_N;
    @(negedge clk);
    if (p == 0) begin req0_a = a; req0_b = b; req0_funct = f; end
    else        begin req1_a = a; req1_b = b; req1_funct = f; end
    req_valid[p] = 1'b1;
    wait_ready(p, ok);
    acc = -1;
    if (ok) begin
      @(posedge clk);
      #1;
      acc = cyc;
      if (expect_rsp) push_exp(p, res, fl, n, acc);
    end
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || sb.size() != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: tracks when rsp_valid rises and scores every completed response.
  initial begin
    bit prev;
    int rise;
    exp_t e;
    prev = 1'b0;
    rise = 0;
    forever begin
      @(negedge clk);
      #3;
      if (!reset) begin
        prev = 1'b0;
      end else begin
        if (rsp_valid != 2'b00 && !prev) rise = cyc;
        prev = (rsp_valid != 2'b00);
        if ((rsp_valid & rsp_ready) != 2'b00) begin
          if (sb.size() == 0) begin
            check("unexpected_rsp", {30'd0, rsp_valid}, 32'd0);
          end else begin
            e = sb.pop_front();
            check("rsp_owner",   {30'd0, rsp_valid}, {30'd0, e.owner_oh});
            check("rsp_result",  rsp_result, e.result);
            check("rsp_flags",   {28'd0, rsp_flags}, {28'd0, e.flags});
            check("rsp_latency", rise, e.acc + e.n);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int ord[4];
    int last_p, other;
    bit ok;
`ifdef FP_SCHED_RR_ARB_EN
    ord = '{0, 1, 0, 1};
`else
    ord = '{0, 0, 0, 0};
`endif

    // Reset state.
    #2;
    check("rst_busy",       {31'd0, busy}, 32'd0);
    check("rst_rsp_valid",  {30'd0, rsp_valid}, 32'd0);
    check("rst_req_ready",  {30'd0, req_ready}, 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_fpu_a",      fpu_a, 32'd0);
    check("rst_fpu_funct",  {26'd0, fpu_funct}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Single add on port 0: busy for exactly N+1 cycles after accept.
    send(0, 32'h3FC00000, 32'h40100000, 6'b000000, 32'h40700000, 4'b0000, 1'b1, acc);
    for (int i = 0; i < ADD_N + 2; i++) begin
      @(negedge clk);
      #1;
      check("add_busy", {31'd0, busy}, (i <= ADD_N) ? 32'd1 : 32'd0);
    end
    wait_idle();

    // Single multiply on port 1: registered operands hold through SETTLE and RESP.
    send(1, 32'h40000000, 32'h40400000, 6'b000010, 32'h40C00000, 4'b0001, 1'b1, acc);
    for (int i = 0; i <= MUL_N; i++) begin
      @(negedge clk);
      #1;
      check("mul_fpu_a",     fpu_a, 32'h40000000);
      check("mul_fpu_b",     fpu_b, 32'h40400000);
      check("mul_fpu_funct", {26'd0, fpu_funct}, 32'h00000002);
    end
    wait_idle();

    // Zero result sets Z.
    send(0, 32'h3F800000, 32'hBF800000, 6'b000000, 32'h00000000, 4'b0100, 1'b1, acc);
    wait_idle();

    // Back-pressure: only the non-owner's rsp_ready is high, so the response stalls.
    @(negedge clk);
    rsp_ready = 2'b10;
    send(0, 32'h3FC00000, 32'h40100000, 6'b000000, 32'h40700000, 4'b0000, 1'b1, acc);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      #1;
      ok = (rsp_valid != 2'b00);
    end
    if (!ok) check("bp_rsp_timeout", 32'd0, 32'd1);
    fork
      send(1, 32'h40000000, 32'h40400000, 6'b000010, 32'h40C00000, 4'b0001, 1'b1, acc);
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          #1;
          check("bp_result",    rsp_result, 32'h40700000);
          check("bp_flags",     {28'd0, rsp_flags}, 32'd0);
          check("bp_rsp_valid", {30'd0, rsp_valid}, 32'd1);
          check("bp_req_ready", {30'd0, req_ready}, 32'd0);
        end
        rsp_ready = 2'b11;
      end
    join
    wait_idle();

    // Reset during the second SETTLE cycle of a multiply drops the operation.
    send(1, 32'h40000000, 32'h40400000, 6'b000010, 32'h40C00000, 4'b0001, 1'b0, acc);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_busy",       {31'd0, busy}, 32'd0);
    check("mid_rst_rsp_valid",  {30'd0, rsp_valid}, 32'd0);
    check("mid_rst_rsp_result", rsp_result, 32'd0);
    check("mid_rst_rsp_flags",  {28'd0, rsp_flags}, 32'd0);
    check("mid_rst_fpu_a",      fpu_a, 32'd0);
    check("mid_rst_fpu_b",      fpu_b, 32'd0);
    check("mid_rst_fpu_funct",  {26'd0, fpu_funct}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_no_rsp", {30'd0, rsp_valid}, 32'd0);
    end

    // Conflict: both requesters hold valid for four operations.
    @(negedge clk);
    req0_a = 32'h3FC00000; req0_b = 32'h40100000; req0_funct = 6'b000000;
    req1_a = 32'h40000000; req1_b = 32'h40400000; req1_funct = 6'b000010;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ready(ord[k], ok);
      check("conflict_grant", {30'd0, req_ready}, (ord[k] == 1) ? 32'd2 : 32'd1);
      if (ok) begin
        @(posedge clk);
        #1;
        if (ord[k] == 1) push_exp(1, 32'h40C00000, 4'b0001, MUL_N, cyc);
        else             push_exp(0, 32'h40700000, 4'b0000, ADD_N, cyc);
      end
      if (k < 3) @(negedge clk);
    end
    last_p = ord[3];
    other  = 1 - last_p;
    req_valid[last_p] = 1'b0;
    @(negedge clk);
    wait_ready(other, ok);
    if (ok) begin
      @(posedge clk);
      #1;
      if (other == 1) push_exp(1, 32'h40C00000, 4'b0001, MUL_N, cyc);
      else            push_exp(0, 32'h40700000, 4'b0000, ADD_N, cyc);
    end
    req_valid = 2'b00;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
